// File: rtl/clk_tick_pkg.sv
// Shared types and constants for the slow-clock tick receiver.
package clk_tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_TRACK,
        ST_LOCKED
    } rx_state_e;

    localparam int                   DEF_CNT_W = 24;
    localparam logic [DEF_CNT_W-1:0] CNT_MAX   = '1;

endpackage

// File: rtl/clk_tick_receiver_sync.sv
// Synchroniser chain plus previous-value flop; emits rise/fall of the synchronised input.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

endmodule

// File: rtl/clk_tick_receiver.sv
// Slow-clock receiver: rising-edge ticks, rise-to-rise period measurement, lock and stall detection.
// Optional falling-edge tick output is enabled by defining CLK_TICK_FALL_EN.
//
// state  | meaning
// IDLE   | no reference edge seen yet (after reset or timeout)
// ARM    | one rise seen, waiting for the first full period
// TRACK  | measuring, counting consecutive in-tolerance periods
// LOCKED | period stable against the held reference
module clk_tick_receiver
    import clk_tick_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk,
    output logic             tick_rise,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
`ifdef CLK_TICK_FALL_EN
    ,
    output logic             tick_fall
`endif
);

    localparam int MATCH_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    // Package CNT_MAX is all-ones; replicate one of its bits to this instance's width.
    localparam logic [CNT_W-1:0]   CNT_TOP    = {CNT_W{CNT_MAX[0]}};
    localparam logic [CNT_W:0]     TOL_W      = (CNT_W + 1)'(TOL);
    localparam logic [MATCH_W-1:0] LOCK_CNT_M = MATCH_W'(LOCK_COUNT);

    logic rise;
    logic fall;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (slow_clk),
        .rise (rise),
        .fall (fall)
    );

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ref_q, ref_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               tick_rise_q, tick_rise_d;
    logic               pv_q, pv_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;

    logic               cnt_sat;
    logic [CNT_W:0]     cnt_x, ref_x, diff;
    logic               in_tol;
    logic [MATCH_W-1:0] match_inc;

    always_comb begin
        cnt_sat   = (cnt_q == CNT_TOP);
        cnt_x     = {1'b0, cnt_q};
        ref_x     = {1'b0, ref_q};
        diff      = (cnt_x >= ref_x) ? (cnt_x - ref_x) : (ref_x - cnt_x);
        in_tol    = (diff <= TOL_W);
        match_inc = match_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        period_d    = period_q;
        match_d     = match_q;
        pv_d        = 1'b0;
        timeout_d   = 1'b0;
        tick_rise_d = rise;
        locked_d    = (state_q == ST_LOCKED);

        if (rise)         cnt_d = CNT_W'(1);
        else if (cnt_sat) cnt_d = cnt_q;
        else              cnt_d = cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (rise) begin
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    ref_d    = cnt_q;
                    match_d  = '0;
                    state_d  = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (rise) begin
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    if (in_tol) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_CNT_M) state_d = ST_LOCKED;
                    end else begin
                        ref_d   = cnt_q;
                        match_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (rise) begin
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    if (!in_tol) begin
                        ref_d   = cnt_q;
                        match_d = '0;
                        state_d = ST_TRACK;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A rise on the saturating cycle is a valid sample, so stall only without a rise.
        if (state_q != ST_IDLE && cnt_sat && !rise) begin
            timeout_d = 1'b1;
            match_d   = '0;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ref_q       <= '0;
            period_q    <= '0;
            match_q     <= '0;
            tick_rise_q <= 1'b0;
            pv_q        <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ref_q       <= ref_d;
            period_q    <= period_d;
            match_q     <= match_d;
            tick_rise_q <= tick_rise_d;
            pv_q        <= pv_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign tick_rise    = tick_rise_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

`ifdef CLK_TICK_FALL_EN
    logic tick_fall_q, tick_fall_d;

    always_comb tick_fall_d = fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_fall_q <= 1'b0;
        else     tick_fall_q <= tick_fall_d;
    end

    assign tick_fall = tick_fall_q;
`else
    logic fall_unused;
    assign fall_unused = fall;
`endif

endmodule

// File: tb/tb_clk_tick_receiver.sv
// Directed bench for clk_tick_receiver (CNT_W=8); checks tick_fall when CLK_TICK_FALL_EN is defined.
module tb_clk_tick_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       slow_clk;
    logic       tick_rise;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       timeout;
`ifdef CLK_TICK_FALL_EN
    logic       tick_fall;
`endif

    int vectors     = 0;
    int miscompares = 0;

    clk_tick_receiver #(
        .SYNC_STAGES(2),
        .CNT_W      (8),
        .LOCK_COUNT (4),
        .TOL        (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .slow_clk     (slow_clk),
        .tick_rise    (tick_rise),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
`ifdef CLK_TICK_FALL_EN
        ,
        .tick_fall    (tick_fall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick_rise"}, tick_rise, 0);
        chk({tag, "_period_valid"}, period_valid, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_period"}, period, 0);
`ifdef CLK_TICK_FALL_EN
        chk({tag, "_tick_fall"}, tick_fall, 0);
`endif
    endtask

    // One slow period starting with a rise; the rise's tick lands at step index 2.
    task automatic slow_period(input int len, input int high, input bit exp_pv,
                               input int exp_per, input bit lk_pre, input bit lk_post);
        slow_clk = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (i == high) slow_clk = 1'b0;
            step();
            chk("tick_rise", tick_rise, (i == 2));
            chk("period_valid", period_valid, (i == 2) && exp_pv);
            if (i == 2 && exp_pv) chk("period", period, exp_per);
            chk("locked", locked, (i <= 2) ? lk_pre : lk_post);
            chk("timeout", timeout, 0);
`ifdef CLK_TICK_FALL_EN
            chk("tick_fall", tick_fall, (i == high + 2));
`endif
        end
    endtask

    initial begin
        int j;
        rst      = 1'b1;
        slow_clk = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (3) step();
        chk_all_zero("reset_held");
        rst = 1'b0;
        repeat (4) step();

        // Square wave of 16: first rise arms, second reports, sixth locks.
        slow_period(16, 8, 0, 0, 0, 0);
        slow_period(16, 8, 1, 16, 0, 0);
        slow_period(16, 8, 1, 16, 0, 0);
        slow_period(16, 8, 1, 16, 0, 0);
        slow_period(16, 8, 1, 16, 0, 0);
        slow_period(17, 8, 1, 16, 0, 1);
        // Jitter within tolerance keeps lock; 19 breaks it and becomes the new reference.
        slow_period(14, 8, 1, 17, 1, 1);
        slow_period(18, 8, 1, 14, 1, 1);
        slow_period(19, 8, 1, 18, 1, 1);
        slow_period(19, 8, 1, 19, 1, 0);
        slow_period(19, 8, 1, 19, 0, 0);
        slow_period(19, 8, 1, 19, 0, 0);
        slow_period(19, 8, 1, 19, 0, 0);
        slow_period(16, 8, 1, 19, 0, 1);

        // Hold low: counter saturates at 255 and raises a one-cycle timeout.
        j = 0;
        while (j < 300) begin
            step();
            if (timeout === 1'b1) break;
            j++;
        end
        chk("timeout_delay", j, 241);
        chk("locked_at_timeout", locked, 1);
        step();
        chk("timeout_width", timeout, 0);
        chk("locked_after_timeout", locked, 0);
        repeat (20) begin
            step();
            chk("timeout_idle", timeout, 0);
        end

        // Re-arm; a 255-cycle period coincides with saturation and must be reported, not timed out.
        slow_period(16, 8, 0, 0, 0, 0);
        slow_period(255, 8, 1, 16, 0, 0);
        slow_period(16, 8, 1, 255, 0, 0);

        // Reset mid-stream while a tick is being presented.
        slow_clk = 1'b1;
        step();
        step();
        step();
        chk("pre_reset_tick", tick_rise, 1);
        chk("pre_reset_pv", period_valid, 1);
        chk("pre_reset_period", period, 16);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        repeat (3) step();
        chk_all_zero("mid_reset_held");
        rst = 1'b0;
        step();
        chk("post_reset_tick0", tick_rise, 0);
        step();
        chk("post_reset_tick1", tick_rise, 0);
        step();
        chk("post_reset_tick2", tick_rise, 1);
        chk("post_reset_pv", period_valid, 0);
        slow_clk = 1'b0;
        repeat (13) step();

        // Quarter duty cycle: same period and lock behaviour, falling ticks at the new position.
        slow_period(16, 4, 1, 16, 0, 0);
        slow_period(16, 4, 1, 16, 0, 0);
        slow_period(16, 4, 1, 16, 0, 0);
        slow_period(16, 4, 1, 16, 0, 0);
        slow_period(16, 4, 1, 16, 0, 1);
        slow_period(16, 4, 1, 16, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
